// File: rtl/mux4_rr_sched_pkg.sv
// Shared constants, channel-index type and round-robin search helper for the
// four-channel sample merger.
package mux4_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    typedef logic [SELW-1:0] ch_t;

    typedef struct packed {
        logic found;
        ch_t  idx;
    } rr_t;

    // Search last+1, last+2, ... wrapping modulo NCH; last itself is checked last.
    function automatic rr_t next_rr(ch_t last, logic [NCH-1:0] req);
        rr_t r;
        ch_t c;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            c = ch_t'(last + ch_t'(i));
            if (!r.found && req[c]) begin
                r.found = 1'b1;
                r.idx   = c;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux4_rr_sched_if.sv
// Source/consumer side bundle of the four-channel sample merger.
interface mux4_rr_sched_if #(parameter int W = 16);
    import mux4_pkg::*;

    logic [W-1:0]   D0, D1, D2, D3;
    logic [NCH-1:0] STB;
    logic [NCH-1:0] ENA;
    logic [NCH-1:0] ACK;
    logic [W-1:0]   Q;
    ch_t            QCH;
    logic           QV;
    logic           RDY;
    logic [NCH-1:0] OVR;
    logic           OVRCLR;

    modport master (
        input  D0, D1, D2, D3, STB, ENA, RDY, OVRCLR,
        output ACK, Q, QCH, QV, OVR
    );

    modport slave (
        output D0, D1, D2, D3, STB, ENA, RDY, OVRCLR,
        input  ACK, Q, QCH, QV, OVR
    );

endinterface

// File: rtl/mux4_rr_sched_reg_w.sv
// Registered 4:1 word mux: loads the selected channel word when CE is high.
module mux4_reg_w
    import mux4_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] D0,
    input  logic [W-1:0] D1,
    input  logic [W-1:0] D2,
    input  logic [W-1:0] D3,
    input  ch_t          S,
    input  logic         CE,
    output logic [W-1:0] Q
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= '0;
        end else if (CE) begin
            case (S)
                2'd0: Q <= D0;
                2'd1: Q <= D1;
                2'd2: Q <= D2;
                2'd3: Q <= D3;
            endcase
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin merger of four strobed sample streams into one tagged stream.
// Optional MUX4_CH0_PRIO_EN: channel 0 gets strict priority over the rotation.
module mux4_rr_sched
    import mux4_pkg::*;
#(
    parameter int W               = 16,
    parameter bit OVR_CLR_ON_READ = 1'b0
) (
    input logic             CLK,
    input logic             RST,
    mux4_rr_sched_if.master bus
);

    logic [NCH-1:0] pend;
    logic [NCH-1:0] pend_nxt;
    logic [NCH-1:0] ovr;
    logic [NCH-1:0] ovr_set;
    logic [NCH-1:0] req;
    logic [NCH-1:0] gnt_oh;
    ch_t            last;
    ch_t            qch;
    logic           qv;
    logic           free;
    logic           grant;
    rr_t            pick;

    always_comb begin
        req = pend & bus.ENA;
`ifdef MUX4_CH0_PRIO_EN
        if (req[0]) begin
            pick.found = 1'b1;
            pick.idx   = '0;
        end else begin
            pick = next_rr(last, req & 4'b1110);
        end
`else
        pick = next_rr(last, req);
`endif
    end

    assign free   = !qv || bus.RDY;
    assign grant  = free && pick.found;
    assign gnt_oh = grant ? (4'b0001 << pick.idx) : 4'b0000;

    // A strobe coinciding with its own grant is a fresh sample, not an overrun.
    always_comb begin
        pend_nxt = pend;
        ovr_set  = '0;
        for (int n = 0; n < NCH; n++) begin
            if (!bus.ENA[n]) begin
                pend_nxt[n] = 1'b0;
            end else if (bus.STB[n]) begin
                pend_nxt[n] = 1'b1;
                ovr_set[n]  = pend[n] && !gnt_oh[n];
            end else if (gnt_oh[n]) begin
                pend_nxt[n] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend <= '0;
            ovr  <= '0;
            last <= 2'd3;
            qv   <= 1'b0;
            qch  <= '0;
        end else begin
            pend <= pend_nxt;
            if (OVR_CLR_ON_READ && bus.OVRCLR) begin
                ovr <= ovr_set;
            end else begin
                ovr <= ovr | ovr_set;
            end
            if (grant) begin
                qv  <= 1'b1;
                qch <= pick.idx;
`ifdef MUX4_CH0_PRIO_EN
                if (pick.idx != '0) begin
                    last <= pick.idx;
                end
`else
                last <= pick.idx;
`endif
            end else if (free) begin
                qv <= 1'b0;
            end
        end
    end

    mux4_reg_w #(.W(W)) u_reg (
        .CLK (CLK),
        .RST (RST),
        .D0  (bus.D0),
        .D1  (bus.D1),
        .D2  (bus.D2),
        .D3  (bus.D3),
        .S   (pick.idx),
        .CE  (grant),
        .Q   (bus.Q)
    );

    assign bus.ACK = gnt_oh;
    assign bus.QCH = qch;
    assign bus.QV  = qv;
    assign bus.OVR = ovr;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched with an expected-output queue.
module tb_mux4_rr_sched;
    import mux4_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    int   checks   = 0;
    int   failures = 0;
    logic [17:0] sb[$];
    logic [1:0]  ord[4];

    mux4_rr_sched_if #(.W(16)) bus ();

    mux4_rr_sched #(.W(16), .OVR_CLR_ON_READ(1'b0)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [15:0] d);
        sb.push_back({ch, d});
    endtask

    // Consumer takes Q at the coming edge when QV and RDY are both high.
    task automatic tick();
        logic [17:0] e;
        #2;
        if (bus.QV && bus.RDY) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed qch=%0d q=%h expected=none", bus.QCH, bus.Q);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_qch", 32'(bus.QCH), 32'(e[17:16]));
                chk("sb_q", 32'(bus.Q), 32'(e[15:0]));
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        bus.D0 = '0; bus.D1 = '0; bus.D2 = '0; bus.D3 = '0;
        bus.STB = '0; bus.ENA = '0; bus.RDY = 1'b0; bus.OVRCLR = 1'b0;
        @(posedge CLK);
        #1;
        tick();
        tick();
        RST = 1'b0;
        chk("rst_q", 32'(bus.Q), 32'h0);
        chk("rst_qch", 32'(bus.QCH), 32'h0);
        chk("rst_qv", 32'(bus.QV), 32'h0);
        chk("rst_ack", 32'(bus.ACK), 32'h0);
        chk("rst_ovr", 32'(bus.OVR), 32'h0);

        // single sample on channel 2
        bus.ENA = 4'hF; bus.RDY = 1'b1; bus.D2 = 16'h1234;
        push(2'd2, 16'h1234);
        bus.STB = 4'b0100; tick(); bus.STB = '0;
        #1 chk("t1_ack", 32'(bus.ACK), 32'h4);
        tick();
        chk("t1_qv", 32'(bus.QV), 32'h1);
        chk("t1_qch", 32'(bus.QCH), 32'h2);
        chk("t1_q", 32'(bus.Q), 32'h1234);
        tick();
        chk("t1_qv_clr", 32'(bus.QV), 32'h0);

        // fairness from reset pointer, then from LAST=1
        RST = 1'b1; tick(); RST = 1'b0;
        bus.D0 = 16'hA000; bus.D1 = 16'hA001; bus.D2 = 16'hA002; bus.D3 = 16'hA003;
        for (int i = 0; i < 4; i++) push(2'(i), 16'hA000 + 16'(i));
        bus.STB = 4'hF; tick(); bus.STB = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_qv", 32'(bus.QV), 32'h1);
            chk("t2_order", 32'(bus.QCH), 32'(i));
            tick();
        end
        chk("t2_qv_end", 32'(bus.QV), 32'h0);
        push(2'd1, 16'hA001);
        bus.STB = 4'b0010; tick(); bus.STB = '0;
        tick();
        tick();
        ord[0] = 2'd2; ord[1] = 2'd3; ord[2] = 2'd0; ord[3] = 2'd1;
        for (int i = 0; i < 4; i++) push(ord[i], 16'hA000 + 16'(ord[i]));
        bus.STB = 4'hF; tick(); bus.STB = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2b_order", 32'(bus.QCH), 32'(ord[i]));
            tick();
        end
        chk("t2b_qv_end", 32'(bus.QV), 32'h0);

        // backpressure with channels 2 and 0 pending (LAST=1)
        bus.RDY = 1'b0; bus.D0 = 16'hB000; bus.D2 = 16'hB002;
        push(2'd2, 16'hB002); push(2'd0, 16'hB000);
        bus.STB = 4'b0101; tick(); bus.STB = '0;
        #1 chk("t3_ack_first", 32'(bus.ACK), 32'h4);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_ack_held", 32'(bus.ACK), 32'h0);
            tick();
            chk("t3_q_held", 32'(bus.Q), 32'hB002);
            chk("t3_qch_held", 32'(bus.QCH), 32'h2);
            chk("t3_qv_held", 32'(bus.QV), 32'h1);
        end
        bus.RDY = 1'b1;
        #1 chk("t3_ack_resume", 32'(bus.ACK), 32'h1);
        tick();
        chk("t3_nobubble_qv", 32'(bus.QV), 32'h1);
        chk("t3_nobubble_qch", 32'(bus.QCH), 32'h0);
        tick();
        chk("t3_qv_end", 32'(bus.QV), 32'h0);

        // overrun on channel 1 while output is blocked
        bus.RDY = 1'b0; bus.D3 = 16'hC003; bus.D1 = 16'hC001;
        push(2'd3, 16'hC003); push(2'd1, 16'hC001);
        bus.STB = 4'b1000; tick(); bus.STB = '0;
        tick();
        bus.STB = 4'b0010; tick(); bus.STB = '0;
        chk("t4_ovr_first", 32'(bus.OVR), 32'h0);
        bus.STB = 4'b0010; tick(); bus.STB = '0;
        chk("t4_ovr_set", 32'(bus.OVR), 32'h2);
        bus.OVRCLR = 1'b1; tick(); bus.OVRCLR = 1'b0;
        chk("t4_ovrclr_ignored", 32'(bus.OVR), 32'h2);
        bus.RDY = 1'b1;
        tick();
        tick();
        chk("t4_qv_end", 32'(bus.QV), 32'h0);

        // strobe coincident with its own ACK is a new sample
        RST = 1'b1; tick(); RST = 1'b0;
        bus.RDY = 1'b1; bus.D1 = 16'hD001;
        push(2'd1, 16'hD001); push(2'd1, 16'hD002);
        bus.STB = 4'b0010; tick();
        #1 chk("t4b_ack", 32'(bus.ACK), 32'h2);
        tick(); bus.STB = '0; bus.D1 = 16'hD002;
        chk("t4b_ovr", 32'(bus.OVR), 32'h0);
        chk("t4b_q1", 32'(bus.Q), 32'hD001);
        tick();
        chk("t4b_q2", 32'(bus.Q), 32'hD002);
        chk("t4b_qv2", 32'(bus.QV), 32'h1);
        tick();
        chk("t4b_qv_end", 32'(bus.QV), 32'h0);
        chk("t4b_ovr_end", 32'(bus.OVR), 32'h0);

        // disabling a pending channel drops its sample
        RST = 1'b1; tick(); RST = 1'b0;
        bus.RDY = 1'b0; bus.ENA = 4'hF; bus.D0 = 16'hE000; bus.D3 = 16'hE003;
        push(2'd0, 16'hE000);
        bus.STB = 4'b0001; tick(); bus.STB = '0;
        tick();
        bus.STB = 4'b1000; tick(); bus.STB = '0;
        bus.ENA = 4'b0111; tick();
        bus.ENA = 4'hF; bus.RDY = 1'b1;
        tick();
        chk("t5_ena_qv", 32'(bus.QV), 32'h0);
        #1 chk("t5_ena_ack", 32'(bus.ACK), 32'h0);
        tick();
        chk("t5_ena_qv2", 32'(bus.QV), 32'h0);

        // reset while a word is held and another is pending
        bus.RDY = 1'b0; bus.D1 = 16'hF001; bus.D2 = 16'hF002;
        bus.STB = 4'b0010; tick(); bus.STB = '0;
        tick();
        bus.STB = 4'b0100; tick(); bus.STB = '0;
        chk("t5_pre_qv", 32'(bus.QV), 32'h1);
        RST = 1'b1; tick(); RST = 1'b0;
        chk("t5_rst_q", 32'(bus.Q), 32'h0);
        chk("t5_rst_qch", 32'(bus.QCH), 32'h0);
        chk("t5_rst_qv", 32'(bus.QV), 32'h0);
        chk("t5_rst_ovr", 32'(bus.OVR), 32'h0);
        #1 chk("t5_rst_ack", 32'(bus.ACK), 32'h0);
        bus.RDY = 1'b1;
        tick();
        tick();
        chk("t5_discard_qv", 32'(bus.QV), 32'h0);

`ifdef MUX4_CH0_PRIO_EN
        // channel 0 strict priority, then 1 and 2 rotate
        RST = 1'b1; tick(); RST = 1'b0;
        bus.RDY = 1'b1; bus.ENA = 4'hF;
        bus.D0 = 16'h5000; bus.D1 = 16'h5001; bus.D2 = 16'h5002;
        for (int i = 0; i < 7; i++) push(2'd0, 16'h5000);
        push(2'd1, 16'h5001); push(2'd2, 16'h5002);
        bus.STB = 4'b0111; tick();
        bus.STB = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("p_ch0_qch", 32'(bus.QCH), 32'h0);
            chk("p_ch0_qv", 32'(bus.QV), 32'h1);
        end
        bus.STB = '0;
        tick();
        chk("p_ch0_last", 32'(bus.QCH), 32'h0);
        tick();
        chk("p_ch1", 32'(bus.QCH), 32'h1);
        tick();
        chk("p_ch2", 32'(bus.QCH), 32'h2);
        tick();
        chk("p_qv_end", 32'(bus.QV), 32'h0);
`endif

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
- Round-robin scheduler plus registered 4:1 datapath that merges four independently strobed sample streams into one tagged output stream.
- Sits between four DSP channel sources (decimator/filter outputs) and a single shared consumer such as a serializer or host FIFO.
- Generates the select and clock-enable for the registered 4:1 word mux, tracks per-channel pending samples, flags overruns and handshakes with the consumer.

Parameters:
- W, 16, sample word width.
- OVR_CLR_ON_READ, 0, when 1 sticky overrun flags clear on an OVRCLR pulse only; when 0 OVRCLR is ignored and flags clear only on reset.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous reset, active-high
- D0,D1,D2,D3  in  W each  channel sample words
- STB  in  4  per-channel new-sample strobe, one cycle
- ENA  in  4  per-channel enable mask
- ACK  out  4  per-channel one-cycle acknowledge: sample captured
- Q  out  W  output sample register
- QCH  out  2  channel number of Q
- QV  out  1  Q valid
- RDY  in  1  consumer accepts Q when QV and RDY both high
- OVR  out  4  sticky per-channel overrun flags
- OVRCLR  in  1  clear overrun flags (see parameter)

Behaviour:
- Clock and reset: one clock CLK; RST synchronous, active-high.
- Reset state: Q=0, QCH=0, QV=0, ACK=0, OVR=0, pending=0, round-robin pointer LAST=3, so channel 0 is searched first.
- Source contract: D_n is valid from its STB cycle until the cycle ACK[n] is high, inclusive.
- Pending flag PEND[n]:
  - Set on STB[n]&ENA[n].
  - Cleared when channel n is granted.
  - If STB[n] arrives in the same cycle as the grant of n, PEND[n] stays set; this is a new sample, not an overrun.
- Overrun: STB[n] while PEND[n]=1 and n is not granted that cycle sets OVR[n]. PEND stays 1 and the held sample is unchanged.
- ENA: clearing ENA[n] clears PEND[n] next cycle; STB[n] is ignored while ENA[n]=0.
- Slot free: FREE = !QV | RDY.
- Grant:
  - Condition: FREE and any PEND&ENA set.
  - Winner: first requesting channel searching LAST+1, LAST+2, ... modulo 4.
  - Effect: select S=winner and CE=1 to the mux register.
  - Next cycle: Q=D_winner sampled at the grant edge, QCH=winner, QV=1, LAST=winner.
  - ACK[winner] is high in the grant cycle itself, combinational from registered state.
- No grant while FREE: QV clears next cycle when RDY is high. Q and QCH hold their last values.
- Not FREE: Q, QCH and QV hold; no ACK.
- Throughput: one sample per cycle when RDY is held high; no bubble between back-to-back grants.
- Latency: STB to QV is 2 cycles minimum (STB edge sets PEND, grant edge loads Q).
- OVRCLR with OVR_CLR_ON_READ=1: clears OVR. An overrun in the same cycle wins and stays set.
- RST mid-operation: all in-flight PEND and the Q word are discarded. No ACK is issued for discarded samples.

Optional Feature:
- Macro: MUX4_CH0_PRIO_EN.
- Defined: channel 0 has strict priority. It is granted whenever PEND[0]&ENA[0] and FREE, regardless of LAST. LAST is not updated on channel-0 grants; channels 1-3 rotate among themselves.
- Undefined: pure 4-way round robin as above.

Decomposition:
- Shared package mux4_pkg:
  - NCH=4 and SELW=2 constants.
  - Channel-index typedef.
  - Function next_rr(last, req), returning the winner index plus a found flag.
- Sub-module mux4_reg_w (parameter W): registered 4:1 word mux with S, CE and synchronous RST.
- The scheduler instantiates it and owns PEND, LAST, QV, QCH, ACK and OVR.

Test Plan:
- Reset and single sample: reset; ENA=4'hF, STB=4'b0100 with D2=16'h1234, RDY=1 -> ACK[2] one cycle after the STB cycle; Q=1234, QCH=2, QV=1 one cycle later; QV=0 the following cycle.
- Fairness: all four strobes together with D0..D3=0xA000..0xA003, RDY=1 -> QCH sequence 0,1,2,3 on consecutive cycles. Repeat with LAST=1 -> order 2,3,0,1.
- Backpressure: RDY=0 with two channels pending -> Q, QCH and QV frozen, no ACK; RDY=1 -> next channel granted in that cycle with no bubble.
- Overrun: STB[1] twice while RDY=0 -> OVR[1]=1 and the first D1 is delivered. STB[1] coincident with ACK[1] -> OVR stays 0 and a second sample is delivered.
- Enable and reset edge cases: ENA[3]=0 while PEND[3] -> never granted and PEND cleared; RST asserted with QV=1 and pending -> all outputs 0 next cycle.
- MUX4_CH0_PRIO_EN defined: continuous STB[0] plus pending 1 and 2 -> channel 0 is granted every eligible cycle. Remove the STB[0] stream -> channels 1 and 2 alternate.
